// File: rtl/spi_gen_pkg.sv
// spi_gen_pkg: shared FSM state, SPI mode struct and width helper for spi_mstr_gen
package spi_gen_pkg;

    typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SCLK half-period divider with per-edge strobe and leading-edge flag
module spi_sclk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    input  logic             cpol,
    output logic             SCLK,
    output logic             strobe,
    output logic             lead
);

    logic [DIV_W-1:0] cnt;
    logic             ph;

    assign strobe = run && (cnt == div);
    assign lead   = ~ph;
    assign SCLK   = cpol ^ ph;

    // count div+1 clks per half period; phase resets whenever the clock is parked
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            ph  <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            ph  <= 1'b0;
        end else if (strobe) begin
            cnt <= '0;
            ph  <= ~ph;
        end else
            cnt <= cnt + 1'b1;

endmodule

// File: rtl/spi_mstr_gen.sv
// spi_mstr_gen: parametrised full-duplex SPI master, all CPOL/CPHA modes, variable length; SPI_LSB_FIRST_EN adds lsb_first
module spi_mstr_gen
    import spi_gen_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_SS = 2,
    parameter int DIV_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wrt,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic [clog2_min1(DATA_W)-1:0] len_m1,
    input  logic [clog2_min1(NUM_SS)-1:0] ss_sel,
    input  logic                          cpol,
    input  logic                          cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic                          lsb_first,
`endif
    input  logic [DIV_W-1:0]              div,
    input  logic                          MISO,
    output logic [NUM_SS-1:0]             SS_n,
    output logic                          SCLK,
    output logic                          MOSI,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             rx_data
);

    localparam int LW = clog2_min1(DATA_W);

    spi_state_t       state;
    spi_mode_t        mode;
    logic [LW-1:0]    len_l;
    logic [DIV_W-1:0] div_l;
    logic [DATA_W-1:0] sr, rsr, ld_sr, sr_nx, rsr_nx;
    logic [LW:0]      ecnt;
    logic [DIV_W:0]   tail;
    logic             run, strobe, lead, smp, last, ld_head, head, head_nx;
`ifdef SPI_LSB_FIRST_EN
    logic             lsb_l;
`endif

    assign run  = (state == FRONT) || (state == SHIFT);
    assign smp  = mode.cpha ^ lead;
    assign last = ecnt == {len_l, 1'b1};

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .div    (div_l),
        .run    (run),
        .cpol   (mode.cpol),
        .SCLK   (SCLK),
        .strobe (strobe),
        .lead   (lead)
    );

    // bit-order dependent load alignment, next-bit selection and receive placement
    always_comb begin
`ifdef SPI_LSB_FIRST_EN
        ld_sr   = lsb_first ? tx_data : tx_data << (LW'(DATA_W - 1) - len_m1);
        ld_head = lsb_first ? tx_data[0] : tx_data[len_m1];
        head    = lsb_l ? sr[0] : sr[DATA_W-1];
        head_nx = lsb_l ? sr[1] : sr[DATA_W-2];
        sr_nx   = lsb_l ? sr >> 1 : sr << 1;
        rsr_nx  = lsb_l ? rsr | (DATA_W'(MISO) << ecnt[LW:1]) : {rsr[DATA_W-2:0], MISO};
`else
        ld_sr   = tx_data << (LW'(DATA_W - 1) - len_m1);
        ld_head = tx_data[len_m1];
        head    = sr[DATA_W-1];
        head_nx = sr[DATA_W-2];
        sr_nx   = sr << 1;
        rsr_nx  = {rsr[DATA_W-2:0], MISO};
`endif
    end

    // transfer FSM: latch on start, shift on SCLK edges, tail of two half periods, then done
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            mode    <= '0;
            len_l   <= '0;
            div_l   <= '0;
            sr      <= '0;
            rsr     <= '0;
            ecnt    <= '0;
            tail    <= '0;
            SS_n    <= '1;
            MOSI    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
`ifdef SPI_LSB_FIRST_EN
            lsb_l   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (wrt && !done) begin
                    mode  <= '{cpol: cpol, cpha: cpha};
                    len_l <= len_m1;
                    div_l <= div;
                    sr    <= ld_sr;
                    rsr   <= '0;
                    ecnt  <= '0;
                    MOSI  <= ld_head;
                    SS_n  <= ~(NUM_SS'(1) << ss_sel);
                    busy  <= 1'b1;
                    state <= FRONT;
`ifdef SPI_LSB_FIRST_EN
                    lsb_l <= lsb_first;
`endif
                end
                FRONT, SHIFT: if (strobe) begin
                    ecnt  <= ecnt + 1'b1;
                    tail  <= '0;
                    state <= last ? BACK : SHIFT;
                    if (smp)
                        rsr <= rsr_nx;
                    if (!smp && !last) begin
                        MOSI <= mode.cpha ? head : head_nx;
                        sr   <= sr_nx;
                    end
                end
                default: begin
                    tail <= tail + 1'b1;
                    if (tail == {div_l, 1'b1}) begin
                        state   <= IDLE;
                        SS_n    <= '1;
                        MOSI    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rsr;
                    end
                end
            endcase
        end

endmodule

// File: tb/tb_spi_mstr_gen.sv
// tb_spi_mstr_gen: directed checks of spi_mstr_gen timing, modes, selects, reset abort and bit order
module tb_spi_mstr_gen;

    logic        clk = 1'b0, rst_n = 1'b0, wrt = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic [15:0] tx_data = '0;
    logic [3:0]  len_m1 = '0;
    logic        ss_sel = 1'b0;
    logic [7:0]  div = '0;
    logic        MISO, lb = 1'b0, miso_v = 1'b0, lsb_first = 1'b0;
    logic [1:0]  SS_n;
    logic        SCLK, MOSI, busy, done;
    logic [15:0] rx_data;

    int          n_vec = 0, n_err = 0;
    int          o_ss0, o_ss1, o_done, o_edges;
    logic [31:0] o_bits, o_rx, o_sclk_end;

    assign MISO = lb ? MOSI : miso_v;

    always #5 clk = ~clk;

    spi_mstr_gen #(.DATA_W(16), .NUM_SS(2), .DIV_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrt       (wrt),
        .tx_data   (tx_data),
        .len_m1    (len_m1),
        .ss_sel    (ss_sel),
        .cpol      (cpol),
        .cpha      (cpha),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .div       (div),
        .MISO      (MISO),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // one transfer with optional reset abort, wrt-on-done and mid-transfer wrt
    task automatic xfer(input logic [15:0] tx, input logic [3:0] len, input logic ss,
                        input logic pol, input logic pha, input logic [7:0] dv, input logic lsb,
                        input int rst_at, input logic wod, input logic mid);
        int   fin, ab;
        logic prev;
        tx_data = tx; len_m1 = len; ss_sel = ss; cpol = pol; cpha = pha; div = dv;
        lsb_first = lsb; wrt = 1'b1;
        o_ss0 = 0; o_ss1 = 0; o_done = 0; o_edges = 0; o_bits = '0; o_rx = '0; o_sclk_end = '0;
        prev = pol; fin = -1; ab = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 0) begin
                wrt = 1'b0;
                chk("sclk_front", 32'(SCLK), 32'(pol));
            end
            if (mid && c == 10) begin
                wrt = 1'b1; tx_data = 16'hFFFF; ss_sel = ~ss; len_m1 = 4'hF;
            end
            if (mid && c == 11)
                wrt = 1'b0;
            if (!SS_n[0]) o_ss0++;
            if (!SS_n[1]) o_ss1++;
            if (SCLK !== prev) begin
                o_edges++;
                if ((prev == pol) ^ pha)
                    o_bits = {o_bits[30:0], MOSI};
                prev = SCLK;
            end
            if (wod)
                wrt = done;
            if (done) begin
                o_done++;
                o_rx = 32'(rx_data);
                o_sclk_end = 32'(SCLK);
                if (fin < 0) fin = c;
            end
            if (rst_at != 0 && o_edges == rst_at && ab < 0) begin
                rst_n = 1'b0;
                #1;
                chk("rst_ss", 32'(SS_n), 32'h3);
                chk("rst_sclk", 32'(SCLK), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                chk("rst_rx", 32'(rx_data), 32'h0);
                ab = c;
            end
            if ((fin >= 0 && c == fin + 3) || (ab >= 0 && c == ab + 20))
                break;
        end
        if (fin < 0 && ab < 0)
            chk("timeout", 32'h0, 32'h1);
        chk("busy_end", 32'(busy), 32'h0);
        chk("mosi_end", 32'(MOSI), 32'h0);
        wrt = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_SS_n", 32'(SS_n), 32'h3);
        chk("rst_SCLK", 32'(SCLK), 32'h0);
        chk("rst_MOSI", 32'(MOSI), 32'h0);
        chk("rst_busy0", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rx0", 32'(rx_data), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        lb = 1'b1;
        xfer(16'h0066, 4'd7, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 0, 1'b0, 1'b0);
        chk("t1_ss0", 32'(o_ss0), 32'd36);
        chk("t1_ss1", 32'(o_ss1), 32'd0);
        chk("t1_mosi", o_bits, 32'h66);
        chk("t1_done", 32'(o_done), 32'd1);
        chk("t1_rx", o_rx, 32'h66);
        chk("t1_edges", 32'(o_edges), 32'd16);

        for (int m = 0; m < 4; m++) begin
            logic [1:0] md;
            md = 2'(m);
            xfer(16'hA5C3, 4'd15, 1'b0, md[1], md[0], 8'd1, 1'b0, 0, 1'b0, 1'b0);
            chk("t2_rx", o_rx, 32'hA5C3);
            chk("t2_mosi", o_bits, 32'hA5C3);
            chk("t2_edges", 32'(o_edges), 32'd32);
            chk("t2_idle", o_sclk_end, 32'(md[1]));
            chk("t2_ss0", 32'(o_ss0), 32'd68);
        end

        lb = 1'b0; miso_v = 1'b0;
        xfer(16'h0001, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 0, 1'b1, 1'b0);
        chk("t3_ss0", 32'(o_ss0), 32'd4);
        chk("t3_mosi", o_bits, 32'h1);
        chk("t3_rx0", o_rx, 32'h0);
        chk("t3_done", 32'(o_done), 32'd1);
        miso_v = 1'b1;
        xfer(16'h0001, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 0, 1'b0, 1'b0);
        chk("t3_rx1", o_rx, 32'h1);

        lb = 1'b1;
        xfer(16'h00C3, 4'd7, 1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 0, 1'b0, 1'b1);
        chk("t4_ss1", 32'(o_ss1), 32'd54);
        chk("t4_ss0", 32'(o_ss0), 32'd0);
        chk("t4_done", 32'(o_done), 32'd1);
        chk("t4_rx", o_rx, 32'hC3);

        xfer(16'h0F0F, 4'd15, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 5, 1'b0, 1'b0);
        chk("t5_done", 32'(o_done), 32'd0);
        xfer(16'h005A, 4'd7, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 0, 1'b0, 1'b0);
        chk("t5_rx", o_rx, 32'h5A);
        chk("t5_done2", 32'(o_done), 32'd1);

`ifdef SPI_LSB_FIRST_EN
        xfer(16'h0001, 4'd7, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 0, 1'b0, 1'b0);
        chk("t6_mosi", o_bits, 32'h80);
        chk("t6_rx", o_rx, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
